// File: rtl/clk_divider_prog.sv
// Programmable integer clock divider with glitch-free ratio reload and a retimed data bit.
// clk_out/tick rise one clk_in edge after a period start; loads are accepted every cycle (no backpressure).
module clk_divider_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             a,
  output logic             clk_out,
  output logic             tick,
  output logic             b,
  output logic             div_pend,
  output logic             div_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] ratio;
  logic [CNT_W-1:0] pend_val;
  logic [CNT_W-1:0] cnt;

  logic             boundary;
  logic             start;
  logic             load_ok;
  logic             load_bad;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   half;

  assign boundary = (cnt == ratio - CNT_W'(1));
  assign start    = en && ((state == IDLE) || boundary);
  assign cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
  // High phase is ceil(N/2), so odd ratios spend the extra cycle high.
  assign half     = ({1'b0, ratio} + (CNT_W+1)'(1)) >> 1;
  assign load_ok  = div_load && (div_val >= CNT_W'(2));
  assign load_bad = div_load && !load_ok;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ratio    <= CNT_W'(DEFAULT_DIV);
      pend_val <= '0;
      div_pend <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      b        <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      tick    <= 1'b0;
      div_err <= load_bad;

      if (start) begin
        state   <= RUN;
        cnt     <= '0;
        clk_out <= 1'b1;
        tick    <= 1'b1;
        b       <= a;
        if (div_pend) begin
          ratio    <= pend_val;
          div_pend <= 1'b0;
        end
      end else if (state == RUN) begin
        if (boundary) begin
          state   <= IDLE;
          cnt     <= '0;
          clk_out <= 1'b0;
        end else begin
          cnt     <= cnt_inc[CNT_W-1:0];
          clk_out <= (cnt_inc < half);
        end
      end

      // Placed after the start logic so a load on a start edge stays pending for the next boundary.
      if (load_ok) begin
        pend_val <= div_val;
        div_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: period-level reference model plus directed scenarios.
module tb_clk_divider_prog;

  localparam int CNT_W = 8;

  logic             clk_in   = 1'b0;
  logic             rst      = 1'b0;
  logic             en       = 1'b0;
  logic [CNT_W-1:0] div_val  = '0;
  logic             div_load = 1'b0;
  logic             a        = 1'b0;
  logic             clk_out, tick, b, div_pend, div_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  clk_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(2)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .a       (a),
    .clk_out (clk_out),
    .tick    (tick),
    .b       (b),
    .div_pend(div_pend),
    .div_err (div_err)
  );

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  // Reference: a period is either running (position m_pos of m_n cycles) or the divider is idle.
  bit m_run, m_pend, m_b, m_tick, m_err;
  int m_pos, m_n, m_pval;
  bit model_on = 1'b0;

  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_run = 0; m_pos = 0; m_n = 2; m_pval = 0;
      m_pend = 0; m_b = 0; m_tick = 0; m_err = 0;
    end else begin
      bit at_end;
      bit go;
      at_end = m_run && (m_pos == m_n - 1);
      go     = en && (!m_run || at_end);
      m_tick = go;
      m_err  = div_load && (int'(div_val) < 2);
      if (go) begin
        if (m_pend) begin
          m_n    = m_pval;
          m_pend = 0;
        end
        m_run = 1;
        m_pos = 0;
        m_b   = a;
      end else if (at_end) begin
        m_run = 0;
        m_pos = 0;
      end else if (m_run) begin
        m_pos++;
      end
      if (div_load && int'(div_val) >= 2) begin
        m_pval = int'(div_val);
        m_pend = 1;
      end
    end
  end

  always @(negedge clk_in) begin
    if (model_on && !rst) begin
      chk("mdl_clk_out", int'(clk_out), int'(m_run && (m_pos < (m_n + 1) / 2)));
      chk("mdl_tick", int'(tick), int'(m_tick));
      chk("mdl_b", int'(b), int'(m_b));
      chk("mdl_div_pend", int'(div_pend), int'(m_pend));
      chk("mdl_div_err", int'(div_err), int'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_tick(input string nm);
    int k = 0;
    @(negedge clk_in);
    while (!tick && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    chk(nm, int'(tick), 1);
  endtask

  // Returns at the negedge following the edge that applied the pending ratio.
  task automatic wait_pend_clear(input string nm);
    int k = 0;
    while (div_pend && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    chk({nm, "_pend"}, int'(div_pend), 0);
    chk({nm, "_tick"}, int'(tick), 1);
  endtask

  // Called at a tick negedge; measures that period up to the next tick.
  task automatic measure(input string nm, input int want_len, input int want_hi);
    int len = 1;
    int hi  = int'(clk_out);
    @(negedge clk_in);
    while (!tick && len < 100) begin
      len++;
      hi += int'(clk_out);
      @(negedge clk_in);
    end
    chk({nm, "_len"}, len, want_len);
    chk({nm, "_hi"}, hi, want_hi);
  endtask

  initial begin
    bit exp_b;
    bit a_edge;

    #1 rst = 1'b1;
    model_on = 1'b1;
    cyc(2);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_b", int'(b), 0);
    chk("rst_div_pend", int'(div_pend), 0);
    chk("rst_div_err", int'(div_err), 0);
    rst = 1'b0;
    cyc(2);
    chk("idle_clk_out", int'(clk_out), 0);

    // Default ratio 2
    en = 1'b1;
    cyc(1); chk("n2_c0_clk", int'(clk_out), 1); chk("n2_c0_tick", int'(tick), 1);
    cyc(1); chk("n2_c1_clk", int'(clk_out), 0); chk("n2_c1_tick", int'(tick), 0);
    cyc(1); chk("n2_c2_clk", int'(clk_out), 1); chk("n2_c2_tick", int'(tick), 1);
    cyc(1); chk("n2_c3_clk", int'(clk_out), 0); chk("n2_pend", int'(div_pend), 0);

    // Load 5 mid-run
    div_val = 8'd5; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    chk("n5_pend_rise", int'(div_pend), 1);
    wait_pend_clear("n5_apply");
    measure("n5_p0", 5, 3);
    measure("n5_p1", 5, 3);

    // Load 7 then 4 before the boundary: 7 is overwritten
    div_val = 8'd7; div_load = 1'b1;
    cyc(1);
    div_val = 8'd4;
    cyc(1);
    div_load = 1'b0;
    wait_pend_clear("n4_apply");
    measure("n4_p0", 4, 2);

    // Rejected loads
    div_val = 8'd1; div_load = 1'b1;
    cyc(1);
    chk("err1_pulse", int'(div_err), 1);
    chk("err1_pend", int'(div_pend), 0);
    div_val = 8'd0;
    cyc(1);
    chk("err0_pulse", int'(div_err), 1);
    div_load = 1'b0;
    cyc(1);
    chk("err_clear", int'(div_err), 0);
    wait_tick("err_tick");
    measure("n4_after_err", 4, 2);

    // N=6, en dropped at cnt=1
    div_val = 8'd6; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    wait_pend_clear("n6_apply");
    cyc(1);
    en = 1'b0;
    cyc(1); chk("n6_cnt2_clk", int'(clk_out), 1);
    cyc(3); chk("n6_cnt5_clk", int'(clk_out), 0); chk("n6_cnt5_tick", int'(tick), 0);
    cyc(10); chk("n6_idle_clk", int'(clk_out), 0); chk("n6_idle_tick", int'(tick), 0);
    en = 1'b1;
    cyc(1); chk("n6_restart_tick", int'(tick), 1); chk("n6_restart_clk", int'(clk_out), 1);

    // N=4 with a toggling every 3 cycles
    div_val = 8'd4; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    wait_pend_clear("n4b_apply");
    exp_b = a;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) a = ~a;
      a_edge = a;
      cyc(1);
      if ((i + 1) % 4 == 0) begin
        exp_b = a_edge;
        chk("retime_tick", int'(tick), 1);
      end
      chk("retime_b", int'(b), int'(exp_b));
    end

    // Async reset during the high phase
    a = 1'b1;
    wait_tick("pre_rst_tick");
    chk("pre_rst_b", int'(b), 1);
    chk("pre_rst_clk", int'(clk_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_clk", int'(clk_out), 0);
    chk("async_rst_b", int'(b), 0);
    chk("async_rst_tick", int'(tick), 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_tick", int'(tick), 1);
    measure("post_rst_n2", 2, 1);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
